// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: producer slot record, register-zero constant,
// counter ceiling and the source-match helper used by hazard detection.
package hazard_scoreboard_pkg;

  // One tracked producer: occupancy, write-enable, load flag and destination.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic [4:0] rd;
  } slot_t;

  localparam logic [4:0]  ZERO_REG   = 5'd0;
  localparam logic [31:0] COUNT_MAX  = 32'hFFFF_FFFF;
  localparam slot_t       SLOT_EMPTY = '{valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0, rd: 5'd0};

  // True when a consumer actually reads a source that names the given register.
  function automatic logic src_hit(input logic used, input logic [4:0] addr,
                                   input logic [4:0] rd);
    return used && (addr == rd);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_pipe_slot.sv
// Single producer slot register. Load wins over bubble; with neither asserted
// the slot holds, which is how a frozen pipeline keeps its contents.
module pipe_slot
  import hazard_scoreboard_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  slot_t slot_r;

  // Slot storage: reset clears, load captures, bubble empties, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_r <= SLOT_EMPTY;
    end else if (load) begin
      slot_r <= d;
    end else if (bubble) begin
      slot_r <= SLOT_EMPTY;
    end else begin
      slot_r <= slot_r;
    end
  end

  assign q = slot_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / branch hazard scoreboard. Tracks the instructions in EXE and MEM,
// stalls ID for one cycle when it consumes a load still in EXE, flushes on a
// taken branch, and counts load-use stall cycles with saturation.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        reg_write_id,
  input  logic        mem_read_id,
  input  logic [4:0]  rd_addr_id,
  input  logic [4:0]  r1_addr_id,
  input  logic [4:0]  r2_addr_id,
  input  logic        r1_used_id,
  input  logic        r2_used_id,
  input  logic        branch_taken_exe,
  input  logic        halt,
  output logic        reg_write_exe,
  output logic        reg_write_mem,
  output logic [4:0]  rd_addr_exe,
  output logic [4:0]  rd_addr_mem,
  output logic        stall_id,
  output logic        bubble_exe,
  output logic        flush_id,
  output logic [31:0] stall_count
);

  slot_t       exe_slot_s;
  slot_t       mem_slot_s;
  slot_t       id_slot_s;
  logic        load_use_s;
  logic        stall_s;
  logic        flush_s;
  logic        bubble_s;
  logic        id_accept_s;
  logic        exe_load_s;
  logic        exe_bubble_s;
  logic        mem_load_s;
  logic [31:0] stall_count_r;

  assign id_slot_s = '{valid: 1'b1, reg_write: reg_write_id,
                       mem_read: mem_read_id, rd: rd_addr_id};

  // Hazard decode: a taken branch overrides load-use, and halt suppresses stalls.
  always_comb begin
    load_use_s = 1'b0;
    stall_s    = 1'b0;
    flush_s    = branch_taken_exe;
    if (exe_slot_s.valid && exe_slot_s.mem_read && (exe_slot_s.rd != ZERO_REG) && id_valid) begin
      load_use_s = src_hit(r1_used_id, r1_addr_id, exe_slot_s.rd) ||
                   src_hit(r2_used_id, r2_addr_id, exe_slot_s.rd);
    end else begin
      load_use_s = 1'b0;
    end
    if (load_use_s && !branch_taken_exe && !halt) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
    bubble_s = flush_s || stall_s;
  end

  // Slot advance control: ID enters EXE only when accepted; halt freezes both.
  always_comb begin
    id_accept_s  = id_valid && !stall_s && !flush_s;
    exe_load_s   = 1'b0;
    exe_bubble_s = 1'b0;
    mem_load_s   = 1'b0;
    if (!halt) begin
      exe_load_s   = id_accept_s;
      exe_bubble_s = !id_accept_s;
      mem_load_s   = 1'b1;
    end else begin
      exe_load_s   = 1'b0;
      exe_bubble_s = 1'b0;
      mem_load_s   = 1'b0;
    end
  end

  pipe_slot u_exe_slot (
    .clk    (clk),
    .rst    (rst),
    .load   (exe_load_s),
    .bubble (exe_bubble_s),
    .d      (id_slot_s),
    .q      (exe_slot_s)
  );

  pipe_slot u_mem_slot (
    .clk    (clk),
    .rst    (rst),
    .load   (mem_load_s),
    .bubble (1'b0),
    .d      (exe_slot_s),
    .q      (mem_slot_s)
  );

  // Saturating count of load-use stall cycles; frozen while halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_r <= 32'd0;
    end else if (stall_s && !halt && (stall_count_r != COUNT_MAX)) begin
      stall_count_r <= stall_count_r + 32'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign reg_write_exe = exe_slot_s.valid && exe_slot_s.reg_write;
  assign reg_write_mem = mem_slot_s.valid && mem_slot_s.reg_write;
  assign rd_addr_exe   = exe_slot_s.rd;
  assign rd_addr_mem   = mem_slot_s.rd;
  assign stall_id      = stall_s;
  assign bubble_exe    = bubble_s;
  assign flush_id      = flush_s;
  assign stall_count   = stall_count_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard. Each step drives one cycle of ID
// inputs, pushes the expected outputs for that cycle to a scoreboard queue,
// and pops/compares them once the outputs have settled before the next edge.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, reg_write_id, mem_read_id;
  logic [4:0]  rd_addr_id, r1_addr_id, r2_addr_id;
  logic        r1_used_id, r2_used_id, branch_taken_exe, halt;
  logic        reg_write_exe, reg_write_mem;
  logic [4:0]  rd_addr_exe, rd_addr_mem;
  logic        stall_id, bubble_exe, flush_id;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  typedef struct {
    logic       rst, iv, rw, mr;
    logic [4:0] rd, r1;
    logic       u1;
    logic [4:0] r2;
    logic       u2, br, hl;
    logic       e_rwe, e_rwm;
    logic [4:0] e_rde, e_rdm;
    logic       e_st, e_bu, e_fl;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[19];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .reg_write_id     (reg_write_id),
    .mem_read_id      (mem_read_id),
    .rd_addr_id       (rd_addr_id),
    .r1_addr_id       (r1_addr_id),
    .r2_addr_id       (r2_addr_id),
    .r1_used_id       (r1_used_id),
    .r2_used_id       (r2_used_id),
    .branch_taken_exe (branch_taken_exe),
    .halt             (halt),
    .reg_write_exe    (reg_write_exe),
    .reg_write_mem    (reg_write_mem),
    .rd_addr_exe      (rd_addr_exe),
    .rd_addr_mem      (rd_addr_mem),
    .stall_id         (stall_id),
    .bubble_exe       (bubble_exe),
    .flush_id         (flush_id),
    .stall_count      (stall_count)
  );

  function automatic vec_t mk(
    input logic rs, input logic iv, input logic rw, input logic mr, input logic [4:0] rd,
    input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
    input logic br, input logic hl,
    input logic e_rwe, input logic e_rwm, input logic [4:0] e_rde, input logic [4:0] e_rdm,
    input logic e_st, input logic e_bu, input logic e_fl, input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rs; v.iv = iv; v.rw = rw; v.mr = mr; v.rd = rd;
    v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2; v.br = br; v.hl = hl;
    v.e_rwe = e_rwe; v.e_rwm = e_rwm; v.e_rde = e_rde; v.e_rdm = e_rdm;
    v.e_st = e_st; v.e_bu = e_bu; v.e_fl = e_fl; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, step_no, act, exp);
    end
  endtask

  // One cycle: drive at negedge, queue expectation, compare after settling.
  task automatic step(input vec_t v, input bit preload);
    vec_t e;
    @(negedge clk);
    rst = v.rst; id_valid = v.iv; reg_write_id = v.rw; mem_read_id = v.mr;
    rd_addr_id = v.rd; r1_addr_id = v.r1; r1_used_id = v.u1;
    r2_addr_id = v.r2; r2_used_id = v.u2; branch_taken_exe = v.br; halt = v.hl;
    sb_q.push_back(v);
    #1;
    e = sb_q.pop_front();
    chk("reg_write_exe", {31'd0, reg_write_exe}, {31'd0, e.e_rwe});
    chk("reg_write_mem", {31'd0, reg_write_mem}, {31'd0, e.e_rwm});
    chk("rd_addr_exe",   {27'd0, rd_addr_exe},   {27'd0, e.e_rde});
    chk("rd_addr_mem",   {27'd0, rd_addr_mem},   {27'd0, e.e_rdm});
    chk("stall_id",      {31'd0, stall_id},      {31'd0, e.e_st});
    chk("bubble_exe",    {31'd0, bubble_exe},    {31'd0, e.e_bu});
    chk("flush_id",      {31'd0, flush_id},      {31'd0, e.e_fl});
    chk("stall_count",   stall_count,            e.e_cnt);
    if (preload) begin
      dut.stall_count_r = 32'hFFFF_FFFF;
    end
    step_no++;
  endtask

  initial begin
    //            rst iv rw mr rd     r1    u1 r2    u2 br hl | rwe rwm rde   rdm   st bu fl cnt
    tbl[0]  = mk(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0,  0, 0, 5'd0, 5'd0, 0, 0, 0, 32'd0); // reset state
    tbl[1]  = mk(0, 1, 1, 1, 5'd5, 5'd0, 0, 5'd0, 0, 0, 0,  0, 0, 5'd0, 5'd0, 0, 0, 0, 32'd0); // load r5
    tbl[2]  = mk(0, 1, 1, 0, 5'd3, 5'd5, 1, 5'd0, 0, 0, 0,  1, 0, 5'd5, 5'd0, 1, 1, 0, 32'd0); // use r5: stall
    tbl[3]  = mk(0, 1, 1, 0, 5'd3, 5'd5, 1, 5'd0, 0, 0, 0,  0, 1, 5'd0, 5'd5, 0, 0, 0, 32'd1); // stall cleared
    tbl[4]  = mk(0, 1, 1, 0, 5'd7, 5'd0, 0, 5'd0, 0, 0, 0,  1, 0, 5'd3, 5'd0, 0, 0, 0, 32'd1); // ALU r7
    tbl[5]  = mk(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd7, 1, 0, 0,  1, 1, 5'd7, 5'd3, 0, 0, 0, 32'd1); // use r7: no stall
    tbl[6]  = mk(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0,  0, 1, 5'd0, 5'd7, 0, 0, 0, 32'd1); // r7 in MEM
    tbl[7]  = mk(0, 1, 1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0,  0, 0, 5'd0, 5'd0, 0, 0, 0, 32'd1); // load r0
    tbl[8]  = mk(0, 1, 0, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0,  1, 0, 5'd0, 5'd0, 0, 0, 0, 32'd1); // use r0: no stall
    tbl[9]  = mk(0, 1, 1, 1, 5'd6, 5'd0, 0, 5'd0, 0, 0, 0,  0, 1, 5'd0, 5'd0, 0, 0, 0, 32'd1); // load r6
    tbl[10] = mk(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd6, 1, 1, 0,  1, 0, 5'd6, 5'd0, 0, 1, 1, 32'd1); // branch + load-use
    tbl[11] = mk(0, 1, 1, 1, 5'd8, 5'd0, 0, 5'd0, 0, 0, 0,  0, 1, 5'd0, 5'd6, 0, 0, 0, 32'd1); // load r8
    tbl[12] = mk(0, 0, 0, 0, 5'd0, 5'd8, 1, 5'd0, 0, 0, 0,  1, 0, 5'd8, 5'd0, 0, 0, 0, 32'd1); // invalid consumer
    tbl[13] = mk(0, 1, 1, 0, 5'd9, 5'd0, 0, 5'd0, 0, 0, 0,  0, 1, 5'd0, 5'd8, 0, 0, 0, 32'd1); // ALU r9
    tbl[14] = mk(0, 1, 1, 0, 5'd4, 5'd0, 0, 5'd0, 0, 0, 1,  1, 0, 5'd9, 5'd0, 0, 0, 0, 32'd1); // halt 1
    tbl[15] = mk(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1,  1, 0, 5'd9, 5'd0, 0, 1, 1, 32'd1); // halt 2 + branch
    tbl[16] = mk(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1,  1, 0, 5'd9, 5'd0, 0, 0, 0, 32'd1); // halt 3
    tbl[17] = mk(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0,  1, 0, 5'd9, 5'd0, 0, 0, 0, 32'd1); // resume
    tbl[18] = mk(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0,  0, 1, 5'd0, 5'd9, 0, 0, 0, 32'd1); // r9 in MEM

    rst = 1'b1; id_valid = 1'b0; reg_write_id = 1'b0; mem_read_id = 1'b0;
    rd_addr_id = 5'd0; r1_addr_id = 5'd0; r2_addr_id = 5'd0;
    r1_used_id = 1'b0; r2_used_id = 1'b0; branch_taken_exe = 1'b0; halt = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i], 1'b0);
    end

    // Saturation: preload the counter, then a load-use must leave it pinned.
    step(mk(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0,  0, 0, 5'd0, 5'd0, 0, 0, 0, 32'd1), 1'b1);
    step(mk(0, 1, 1, 1, 5'd5, 5'd0, 0, 5'd0, 0, 0, 0,  0, 0, 5'd0, 5'd0, 0, 0, 0, 32'hFFFF_FFFF), 1'b0);
    step(mk(0, 1, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0, 0, 0,  1, 0, 5'd5, 5'd0, 1, 1, 0, 32'hFFFF_FFFF), 1'b0);
    step(mk(0, 1, 1, 1, 5'd5, 5'd0, 0, 5'd0, 0, 0, 0,  0, 1, 5'd0, 5'd5, 0, 0, 0, 32'hFFFF_FFFF), 1'b0);
    // Reset asserted in the middle of a stall cycle wins over everything.
    step(mk(1, 1, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0, 0, 0,  1, 0, 5'd5, 5'd0, 1, 1, 0, 32'hFFFF_FFFF), 1'b0);
    step(mk(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0,  0, 0, 5'd0, 5'd0, 0, 0, 0, 32'd0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have the port id_valid, input, 1 bit: the ID stage holds a real instruction.
REQ-004 SHALL have the ports reg_write_id, mem_read_id, inputs, 1 bit each: the ID instruction writes rd / is a load.
REQ-005 SHALL have the port rd_addr_id, input, 5 bits: the ID destination register.
REQ-006 SHALL have the ports r1_addr_id, r2_addr_id, inputs, 5 bits each: the ID source registers.
REQ-007 SHALL have the ports r1_used_id, r2_used_id, inputs, 1 bit each: the ID instruction reads that source.
REQ-008 SHALL have the port branch_taken_exe, input, 1 bit: the EXE instruction redirects the PC.
REQ-009 SHALL have the port halt, input, 1 bit: freeze all tracked state.
REQ-010 SHALL have the ports reg_write_exe, reg_write_mem, outputs, 1 bit each: the tracked producer write-enables.
REQ-011 SHALL have the ports rd_addr_exe, rd_addr_mem, outputs, 5 bits each: the tracked producer destinations.
REQ-012 SHALL have the port stall_id, output, 1 bit: hold the PC and the IF/ID register.
REQ-013 SHALL have the port bubble_exe, output, 1 bit: load a NOP into ID/EXE.
REQ-014 SHALL have the port flush_id, output, 1 bit: clear IF/ID.
REQ-015 SHALL have the port stall_count, output, 32 bits: the number of load-use stall cycles.

Function
REQ-016 SHALL keep two producer slots, EXE and MEM, each holding {valid, reg_write, mem_read, rd}.
REQ-017 SHALL, on each non-halted edge, move the EXE slot into the MEM slot.
REQ-018 SHALL, on the same edge, load the EXE slot from the ID inputs when id_valid=1, stall_id=0 and flush_id=0; otherwise it SHALL load an invalid slot (bubble).
REQ-019 SHALL drive reg_write_exe/mem = slot.valid AND slot.reg_write, and SHALL drive rd_addr_exe/mem = slot.rd.
REQ-020 SHALL detect load-use combinationally: EXE valid, EXE mem_read=1, EXE rd != 0, id_valid=1, and (r1_used_id=1 with r1_addr_id = EXE rd, or r2_used_id=1 with r2_addr_id = EXE rd).
REQ-021 SHALL assert stall_id=1 and bubble_exe=1 on load-use; the stall SHALL last exactly one cycle because the load moves to MEM and the hazard clears.
REQ-022 SHALL assert flush_id=1 and bubble_exe=1 when branch_taken_exe=1, and stall_id SHALL be 0 in that cycle (branch takes priority over load-use).
REQ-023 SHALL increment stall_count by 1 on each edge where stall_id=1 and halt=0, and SHALL saturate it at 32'hFFFF_FFFF.
REQ-024 SHALL, when halt=1, leave the slots and stall_count unchanged, drive stall_id=0, and still drive flush_id and bubble_exe per REQ-022.
REQ-025 SHALL ignore rd=0 producers for hazard purposes, while still tracking them.
REQ-026 SHALL ignore id_valid=0 consumers: stall_id=0 for them.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, invalidate both slots, clear all slot fields to 0, and clear stall_count to 0.
REQ-028 SHALL hold all outputs at 0 in the cycle after reset; rst SHALL take priority over halt and over all other inputs, including in the middle of a stall.

Structure
REQ-029 SHALL take the slot record type and the constant ZERO_REG=5'd0 from the shared pipeline package.
REQ-030 SHALL instantiate one sub-module, pipe_slot, a register for a single slot with load/bubble/hold controls, once for EXE and once for MEM.

Verification
REQ-031 SHALL cover the load-use case: a load with rd=5 followed by an instruction using r1=5 -> stall_id=1 and bubble_exe=1 for one cycle; next cycle rd_addr_mem=5, reg_write_mem=1, stall_id=0, stall_count=1.
REQ-032 SHALL cover an ALU producer: a non-load with rd=7 followed by a consumer with r2=7 -> no stall; rd_addr_exe=7 and reg_write_exe=1 for one cycle, then rd_addr_mem=7.
REQ-033 SHALL cover a simultaneous branch and load-use: branch_taken_exe=1 in the same cycle as the load-use condition -> flush_id=1, bubble_exe=1, stall_id=0, stall_count unchanged.
REQ-034 SHALL cover the r0 case: a load with rd=0 followed by a consumer with r1=0 -> stall_id=0, reg_write_exe=1, rd_addr_exe=0.
REQ-035 SHALL cover halt: halt=1 for 3 cycles while EXE holds rd=9 -> rd_addr_exe stays 9, MEM slot unchanged, stall_count unchanged.
REQ-036 SHALL cover saturation and reset: preload stall_count=32'hFFFF_FFFF and trigger a load-use -> count stays 32'hFFFF_FFFF; a rst pulse during the stall -> all outputs and the count read 0 on the next cycle.
